gemm_result_reader: RTL and testbench
=====================================

# gemm_result_reader

Drains the output matrix C from the single-port output SRAM after the GeMM accelerator has finished writing it. It issues row-major reads, absorbs the 1-cycle SRAM read latency, and presents the words on a valid/ready stream with full backpressure support. It sits between `i_sram_c`'s port (muxed in when the accelerator is idle) and the host-side result sink.

## Interface
- `OutDataWidth`, 32, width of a C element and of the output stream.
- `AddrWidth`, 12, SRAM address width (DataDepth 4096).
- `SizeAddrWidth`, 8, width of the M/N size inputs.
- `clk_i` in 1: clock; all logic on the rising edge.
- `rst_ni` in 1: reset, synchronous, active-low.
- `start_i` in 1: single-cycle start; sizes and base are sampled on this edge.
- `M_size_i` in SizeAddrWidth: number of rows of C.
- `N_size_i` in SizeAddrWidth: number of columns of C.
- `base_addr_i` in AddrWidth: SRAM address of C[0][0].
- `sram_c_addr_o` out AddrWidth: read address.
- `sram_c_req_o` out 1: high in any cycle a read is issued; used by the port mux.
- `sram_c_rdata_i` in OutDataWidth: read data, valid the cycle after the address.
- `out_data_o` out OutDataWidth: stream data.
- `out_valid_o` out 1: stream valid.
- `out_ready_i` in 1: stream ready.
- `out_last_o` out 1: marks element C[M-1][N-1]; qualified by `out_valid_o`.
- `busy_o` out 1: transfer in progress.
- `done_o` out 1: single-cycle pulse at transfer end.

## Operation
- States: IDLE, READ, DRAIN.
  - IDLE: `start_i`=1 latches M, N, and base.
    - If M*N = 0, go to IDLE and pulse `done_o` next cycle.
    - Otherwise go to READ.
  - READ: issue reads while the issue condition holds.
    - After the final read issues, go to DRAIN.
  - DRAIN: wait until the buffer is empty and no read is in flight.
    - Then pulse `done_o` and return to IDLE.
- Total = M*N, computed at 2*SizeAddrWidth bits with no truncation.
  - Issue index i runs 0..total-1.
  - `sram_c_addr_o` = base + i, modulo 2^AddrWidth, so it wraps past 4095 to 0.
- Buffer: 2-entry FIFO holding read data.
  - A read issues only when occupancy + in-flight reads < 2.
  - The buffer never overflows and no read is ever dropped.
- Returning data (`sram_c_rdata_i` one cycle after issue) is written into the FIFO that cycle.
- Stream rules:
  - Output is the FIFO head.
  - A handshake occurs when `out_valid_o` and `out_ready_i` are both high.
  - While valid and not ready, `out_data_o`/`out_last_o` hold stable and valid stays high.
  - A push and a pop in the same cycle leave occupancy unchanged.
- `out_last_o` is carried as a FIFO tag set on the read with i = total-1.
- `start_i` while `busy_o`=1 is ignored.
  - Sizes are not re-sampled.
- `sram_c_addr_o` = 0 when no read is issued.
- `busy_o` is high from the cycle after an accepted start through the cycle `done_o` pulses.

## Timing
- Reset values (synchronous, while `rst_ni`=0):
  - State IDLE, FIFO empty, in-flight cleared, counters 0.
  - `sram_c_req_o`, `sram_c_addr_o`, `out_valid_o`, `out_last_o`, `busy_o`, `done_o` all 0.
  - `out_data_o` is 0.
- Reset mid-transfer: the in-flight read is discarded and no stale data appears after reset.
- Latency, with the start edge at cycle 0:
  - Cycle 1: first address (base) with `sram_c_req_o`=1.
  - Cycle 2: data written to the FIFO.
  - Cycle 3: `out_valid_o`=1.
- Throughput: with `out_ready_i` held at 1, one element per cycle sustained, no bubbles after the first.
- `done_o` pulses the cycle after the handshake carrying `out_last_o`.
  - `busy_o` falls in the following cycle.
- Zero size: `done_o`=1 in cycle 1; `out_valid_o` never asserts.
- A new `start_i` is accepted in the cycle after `done_o`.

## Test plan
- M=2, N=3, base=0x010, C[k]=0x100+k, ready=1:
  - Addresses 0x010..0x015 in cycles 1..6.
  - Data 0x100..0x105 valid in cycles 3..8.
  - Last with 0x105; `done_o` in cycle 9.
- Same transfer with `out_ready_i` toggling 1,0,0,1,…:
  - All 6 words in order, none duplicated.
  - Data held stable during stalls.
  - At most 2 reads outstanding plus buffered at any time.
  - Last only on 0x105.
- M=0, N=5:
  - `done_o` cycle 1.
  - No `sram_c_req_o`, no `out_valid_o`.
- M=1, N=4, base=4094:
  - Addresses 4094, 4095, 0, 1.
  - Four words, last on the fourth.
- `start_i` with M=3, N=3 pulsed again mid-transfer with M=1, N=1:
  - Exactly 9 words delivered; second start ignored.
- M=4, N=4, `out_ready_i`=0, `rst_ni` low 1 cycle after 2 reads:
  - All outputs 0 after the reset edge.
  - Next start with M=1, N=1 yields exactly one word, with no stale data.

Source files
------------

// File: rtl/gemm_result_reader_if.sv
// rtl/gemm_result_reader_if.sv - result stream handshake bundle for the GeMM C-matrix reader
interface gemm_result_reader_if #(
  parameter int DataWidth = 32
) ();
  logic [DataWidth-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/gemm_result_reader.sv
// rtl/gemm_result_reader.sv - drains matrix C from the output SRAM onto a backpressured stream
module gemm_result_reader #(
  parameter int OutDataWidth  = 32,
  parameter int AddrWidth     = 12,
  parameter int SizeAddrWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  input  logic [AddrWidth-1:0]     base_addr_i,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic                     sram_c_req_o,
  input  logic [OutDataWidth-1:0]  sram_c_rdata_i,
  gemm_result_reader_if.master     res,
  output logic                     busy_o,
  output logic                     done_o
);
  localparam int TotW = 2 * SizeAddrWidth;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [TotW-1:0]         total_q, idx_q, total_new;
  logic [AddrWidth-1:0]    base_q;
  logic                    zero_done_q, zero_done_d;
  logic                    inflight_q, inflight_last_q;
  logic [OutDataWidth-1:0] fifo_data [2];
  logic [1:0]              fifo_last;
  logic                    wr_ptr_q, rd_ptr_q;
  logic [1:0]              count_q;
  logic                    accept, issue, final_idx, push, pop, drained;
  logic [2:0]              pending;

  assign total_new = TotW'(M_size_i) * TotW'(N_size_i);
  assign push      = inflight_q;
  assign pop       = res.out_valid & res.out_ready;
  // Counting this cycle's pop lets a read issue into the slot being freed, so a
  // ready sink sees one word per cycle with only two slots of storage.
  assign pending   = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign final_idx = (idx_q == total_q - TotW'(1));
  assign drained   = (count_q == 2'd0) && !inflight_q;

  always_comb begin
    state_d     = state_q;
    zero_done_d = 1'b0;
    issue       = 1'b0;
    accept      = 1'b0;
    done_o      = zero_done_q;
    case (state_q)
      IDLE: begin
        if (start_i && !zero_done_q) begin
          accept = 1'b1;
          if (total_new == '0) zero_done_d = 1'b1;
          else                 state_d     = READ;
        end
      end
      READ: begin
        if (pending < 3'd2) begin
          issue = 1'b1;
          if (final_idx) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sram_c_req_o  = issue;
  assign sram_c_addr_o = issue ? base_q + AddrWidth'(idx_q) : '0;
  assign busy_o        = (state_q != IDLE) || zero_done_q;

  assign res.out_valid = (count_q != 2'd0);
  assign res.out_data  = res.out_valid ? fifo_data[rd_ptr_q] : '0;
  assign res.out_last  = res.out_valid & fifo_last[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      zero_done_q     <= 1'b0;
      total_q         <= '0;
      idx_q           <= '0;
      base_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data[0]    <= '0;
      fifo_data[1]    <= '0;
      fifo_last       <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= '0;
    end else begin
      state_q     <= state_d;
      zero_done_q <= zero_done_d;
      if (accept) begin
        total_q <= total_new;
        base_q  <= base_addr_i;
        idx_q   <= '0;
      end else if (issue) begin
        idx_q <= idx_q + TotW'(1);
      end
      inflight_q      <= issue;
      inflight_last_q <= issue && final_idx;
      if (push) begin
        fifo_data[wr_ptr_q] <= sram_c_rdata_i;
        fifo_last[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_gemm_result_reader.sv
// tb/tb_gemm_result_reader.sv - randomized scoreboard bench for gemm_result_reader
module tb_gemm_result_reader;
  bit          clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [7:0]  M_size_i, N_size_i;
  logic [11:0] base_addr_i;
  logic [11:0] sram_c_addr_o;
  logic        sram_c_req_o;
  logic [31:0] sram_c_rdata_i;
  logic        busy_o, done_o;

  gemm_result_reader_if #(.DataWidth(32)) res_if ();

  gemm_result_reader dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
    .M_size_i(M_size_i), .N_size_i(N_size_i), .base_addr_i(base_addr_i),
    .sram_c_addr_o(sram_c_addr_o), .sram_c_req_o(sram_c_req_o),
    .sram_c_rdata_i(sram_c_rdata_i), .res(res_if),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  logic [31:0] sram [4096];
  int n_checks = 0, n_err = 0;
  int cyc = 0, t0 = 0, rel;
  int issued, accepted, total, base_v;
  bit mon_en = 1'b0, strict, done_seen;
  bit prev_valid, prev_ready, prev_last;
  logic [31:0] prev_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (sram_c_req_o) sram_c_rdata_i <= sram[sram_c_addr_o];
    else              sram_c_rdata_i <= $urandom;
  end

  // Scoreboard: expected stream is sram[(base+k) mod 4096] for k = 0..M*N-1.
  always @(negedge clk) begin
    if (mon_en) begin
      rel = cyc - t0;
      if (sram_c_req_o) begin
        chk("req_in_range", issued < total, 1);
        chk("addr", sram_c_addr_o, (base_v + issued) & 4095);
        if (strict) chk("addr_cycle", rel, issued + 1);
        issued++;
      end else begin
        chk("addr_idle", sram_c_addr_o, 0);
      end
      if (prev_valid && !prev_ready) begin
        chk("stall_valid", res_if.out_valid, 1);
        chk("stall_data", res_if.out_data, prev_data);
        chk("stall_last", res_if.out_last, prev_last);
      end
      if (res_if.out_valid) begin
        chk("valid_in_range", accepted < total, 1);
        if (accepted < total) begin
          chk("data", res_if.out_data, sram[(base_v + accepted) & 4095]);
          chk("last", res_if.out_last, accepted == total - 1);
          if (strict) chk("valid_cycle", rel, accepted + 3);
        end
        if (res_if.out_ready) accepted++;
      end
      chk("outstanding_le2", (issued - accepted) <= 2, 1);
      if (done_o) begin
        chk("done_once", done_seen, 0);
        chk("done_count", accepted, total);
        chk("busy_at_done", busy_o, 1);
        if (strict) chk("done_cycle", rel, (total == 0) ? 1 : total + 3);
        done_seen = 1'b1;
      end
      prev_valid = res_if.out_valid;
      prev_ready = res_if.out_ready;
      prev_data  = res_if.out_data;
      prev_last  = res_if.out_last;
    end
  end

  task automatic arm(input int m, input int n, input int b, input bit s);
    total = m * n; base_v = b; strict = s;
    issued = 0; accepted = 0; done_seen = 1'b0;
    prev_valid = 1'b0; prev_ready = 1'b0;
    @(posedge clk); #1;
    M_size_i = 8'(m); N_size_i = 8'(n); base_addr_i = 12'(b); start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    t0 = cyc - 1;
    mon_en = 1'b1;
  endtask

  function automatic logic ready_for(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 3) == 1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run(input int m, input int n, input int b, input int mode, input bit restart);
    int k;
    arm(m, n, b, mode == 0);
    k = 1;
    res_if.out_ready = ready_for(mode, k);
    while (!done_seen && k < 400) begin
      @(posedge clk); #1;
      k++;
      res_if.out_ready = ready_for(mode, k);
      start_i = restart && (k == 4);
      if (restart && k == 4) begin
        M_size_i = 8'd1; N_size_i = 8'd1; base_addr_i = 12'd0;
      end
    end
    mon_en = 1'b0;
    start_i = 1'b0;
    chk("done_seen", done_seen, 1);
    chk("words", accepted, total);
    chk("reads", issued, total);
    chk("busy_after_done", busy_o, 0);
    res_if.out_ready = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; M_size_i = '0; N_size_i = '0; base_addr_i = '0;
    res_if.out_ready = 1'b0;
    for (int i = 0; i < 4096; i++) sram[i] = $urandom;
    for (int i = 0; i < 6; i++) sram[16 + i] = 32'h100 + 32'(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", sram_c_req_o, 0);
    chk("rst_addr", sram_c_addr_o, 0);
    chk("rst_valid", res_if.out_valid, 0);
    chk("rst_data", res_if.out_data, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    rst_ni = 1'b1;

    run(2, 3, 16, 0, 0);
    run(2, 3, 16, 1, 0);
    run(0, 5, 100, 0, 0);
    run(1, 4, 4094, 0, 0);
    run(3, 3, 200, 0, 1);

    arm(4, 4, 32, 1'b0);
    res_if.out_ready = 1'b0;
    for (int k = 0; k < 10 && issued < 2; k++) begin
      @(posedge clk); #1;
    end
    chk("two_reads_before_reset", issued, 2);
    mon_en = 1'b0;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    chk("mid_rst_req", sram_c_req_o, 0);
    chk("mid_rst_addr", sram_c_addr_o, 0);
    chk("mid_rst_valid", res_if.out_valid, 0);
    chk("mid_rst_last", res_if.out_last, 0);
    chk("mid_rst_data", res_if.out_data, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_done", done_o, 0);
    run(1, 1, 40, 0, 0);

    for (int r = 0; r < 10; r++) begin
      int m, n, b, md;
      m  = $urandom_range(0, 4);
      n  = $urandom_range(0, 5);
      b  = $urandom_range(0, 4095);
      md = $urandom_range(0, 2);
      run(m, n, b, md, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
